// File: rtl/n1_sbus_ram_pkg.sv
// Shared types and helpers for the N1 stack-bus RAM target.
// N1_SBUS_RAM_CLR_EN adds the post-reset INIT clearing sweep.
package n1_sbus_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_INIT = 2'b10
    } state_e;

    localparam int WAIT_CNT_W = 4;

    function automatic int ram_depth(input int ps_size, input int rs_size);
        return ps_size + rs_size;
    endfunction

endpackage

// File: rtl/n1_sbus_ram_mem.sv
// Single-port 16-bit synchronous RAM with registered read.
// The read register only updates on a read, so it holds its value across writes.
module n1_sbus_ram_mem #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem_q [DEPTH];
    logic [15:0] rdata_q;
    logic [15:0] rdata_d;

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 16'h0000;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/n1_sbus_ram.sv
// Wishbone pipelined target holding parameter and return stacks in one RAM.
// Define N1_SBUS_RAM_CLR_EN to zero the whole RAM in an INIT sweep after reset.
module n1_sbus_ram
    import n1_sbus_ram_pkg::*;
#(
    parameter int SP_WIDTH    = 12,
    parameter int PS_SIZE     = 256,
    parameter int RS_SIZE     = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk_i,
    input  logic                async_rst_i,
    input  logic                sbus_cyc_i,
    input  logic                sbus_stb_i,
    input  logic                sbus_we_i,
    input  logic [SP_WIDTH-1:0] sbus_adr_i,
    input  logic [15:0]         sbus_dat_i,
    input  logic                sbus_tga_ps_i,
    input  logic                sbus_tga_rs_i,
    output logic                sbus_ack_o,
    output logic                sbus_err_o,
    output logic                sbus_rty_o,
    output logic                sbus_stall_o,
    output logic [15:0]         sbus_dat_o,
    output logic [1:0]          prb_sbus_ram_state_o
);

    localparam int DEPTH = ram_depth(PS_SIZE, RS_SIZE);
    localparam int AW    = $clog2(DEPTH);

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  pend_err_q, pend_err_d;
    logic                  stall;
    logic                  accept;
    logic                  acc_valid;
    logic [AW-1:0]         acc_idx;
    logic                  mem_en;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [15:0]           mem_wdata;
`ifdef N1_SBUS_RAM_CLR_EN
    logic [AW-1:0]         clr_idx_q, clr_idx_d;
`endif

    // Range check uses the full address so out-of-range indices never wrap into the other stack.
    always_comb begin
        acc_valid = 1'b0;
        acc_idx   = AW'(sbus_adr_i);
        if (sbus_tga_ps_i && !sbus_tga_rs_i) begin
            acc_valid = 32'(sbus_adr_i) < 32'(PS_SIZE);
        end else if (sbus_tga_rs_i && !sbus_tga_ps_i) begin
            acc_valid = 32'(sbus_adr_i) < 32'(RS_SIZE);
            acc_idx   = AW'(sbus_adr_i) + AW'(PS_SIZE);
        end
    end

    assign accept = sbus_cyc_i & sbus_stb_i & ~stall;

    always_comb begin
        mem_en    = accept & acc_valid;
        mem_we    = sbus_we_i;
        mem_addr  = acc_idx;
        mem_wdata = sbus_dat_i;
`ifdef N1_SBUS_RAM_CLR_EN
        if (state_q == ST_INIT) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_idx_q;
            mem_wdata = 16'h0000;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
`ifdef N1_SBUS_RAM_CLR_EN
            state_q   <= ST_INIT;
            clr_idx_q <= '0;
`else
            state_q   <= ST_IDLE;
`endif
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            pend_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            pend_err_q <= pend_err_d;
`ifdef N1_SBUS_RAM_CLR_EN
            clr_idx_q  <= clr_idx_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_err_d = pend_err_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
`ifdef N1_SBUS_RAM_CLR_EN
        clr_idx_d  = clr_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        ack_d = acc_valid;
                        err_d = ~acc_valid;
                    end else begin
                        state_d    = ST_WAIT;
                        cnt_d      = WAIT_CNT_W'(WAIT_STATES);
                        pend_err_d = ~acc_valid;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // Dropping cyc abandons the response; a write already landed at acceptance.
                if (!sbus_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == WAIT_CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    ack_d   = ~pend_err_q;
                    err_d   = pend_err_q;
                end
            end
`ifdef N1_SBUS_RAM_CLR_EN
            ST_INIT: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall                = (state_q != ST_IDLE);
        sbus_stall_o         = stall;
        sbus_ack_o           = ack_q & sbus_cyc_i;
        sbus_err_o           = err_q & sbus_cyc_i;
        sbus_rty_o           = 1'b0;
        prb_sbus_ram_state_o = state_q;
    end

    n1_sbus_ram_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk_i),
        .rst_n (async_rst_i),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (sbus_dat_o)
    );

endmodule

// File: tb/tb_n1_sbus_ram.sv
// Directed bench for n1_sbus_ram: instance a runs with no wait states, instance b with three.
// The INIT sweep checks apply when N1_SBUS_RAM_CLR_EN is defined.
module tb_n1_sbus_ram;

    logic        clk;
    logic        rst_n;

    logic        a_cyc, a_stb, a_we, a_ps, a_rs;
    logic [11:0] a_adr;
    logic [15:0] a_dat_i, a_dat_o;
    logic        a_ack, a_err, a_rty, a_stall;
    logic [1:0]  a_prb;

    logic        b_cyc, b_stb, b_we, b_ps, b_rs;
    logic [11:0] b_adr;
    logic [15:0] b_dat_i, b_dat_o;
    logic        b_ack, b_err, b_rty, b_stall;
    logic [1:0]  b_prb;

    int n_chk;
    int n_fail;

`ifdef N1_SBUS_RAM_CLR_EN
    localparam logic       RST_STALL = 1'b1;
    localparam logic [1:0] RST_PRB   = 2'b10;
`else
    localparam logic       RST_STALL = 1'b0;
    localparam logic [1:0] RST_PRB   = 2'b00;
`endif

    n1_sbus_ram #(.SP_WIDTH(12), .PS_SIZE(256), .RS_SIZE(256), .WAIT_STATES(0)) dut_a (
        .clk_i                (clk),
        .async_rst_i          (rst_n),
        .sbus_cyc_i           (a_cyc),
        .sbus_stb_i           (a_stb),
        .sbus_we_i            (a_we),
        .sbus_adr_i           (a_adr),
        .sbus_dat_i           (a_dat_i),
        .sbus_tga_ps_i        (a_ps),
        .sbus_tga_rs_i        (a_rs),
        .sbus_ack_o           (a_ack),
        .sbus_err_o           (a_err),
        .sbus_rty_o           (a_rty),
        .sbus_stall_o         (a_stall),
        .sbus_dat_o           (a_dat_o),
        .prb_sbus_ram_state_o (a_prb)
    );

    n1_sbus_ram #(.SP_WIDTH(12), .PS_SIZE(256), .RS_SIZE(256), .WAIT_STATES(3)) dut_b (
        .clk_i                (clk),
        .async_rst_i          (rst_n),
        .sbus_cyc_i           (b_cyc),
        .sbus_stb_i           (b_stb),
        .sbus_we_i            (b_we),
        .sbus_adr_i           (b_adr),
        .sbus_dat_i           (b_dat_i),
        .sbus_tga_ps_i        (b_ps),
        .sbus_tga_rs_i        (b_rs),
        .sbus_ack_o           (b_ack),
        .sbus_err_o           (b_err),
        .sbus_rty_o           (b_rty),
        .sbus_stall_o         (b_stall),
        .sbus_dat_o           (b_dat_o),
        .prb_sbus_ram_state_o (b_prb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic a_req(input logic ps, input logic rs, input logic we,
                         input logic [11:0] adr, input logic [15:0] dat);
        a_cyc = 1'b1; a_stb = 1'b1; a_ps = ps; a_rs = rs; a_we = we; a_adr = adr; a_dat_i = dat;
    endtask

    task automatic b_req(input logic ps, input logic rs, input logic we,
                         input logic [11:0] adr, input logic [15:0] dat);
        b_cyc = 1'b1; b_stb = 1'b1; b_ps = ps; b_rs = rs; b_we = we; b_adr = adr; b_dat_i = dat;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        a_cyc = 0; a_stb = 0; a_we = 0; a_ps = 0; a_rs = 0; a_adr = '0; a_dat_i = '0;
        b_cyc = 0; b_stb = 0; b_we = 0; b_ps = 0; b_rs = 0; b_adr = '0; b_dat_i = '0;
        step();
        step();

        chk("rst_ack",   32'(a_ack),   0);
        chk("rst_err",   32'(a_err),   0);
        chk("rst_stall", 32'(a_stall), 32'(RST_STALL));
        chk("rst_dat",   32'(a_dat_o), 32'h0000);
        chk("rst_prb",   32'(a_prb),   32'(RST_PRB));
        chk("rst_prb_b", 32'(b_prb),   32'(RST_PRB));
        chk("rst_rty",   32'(a_rty),   0);
        rst_n = 1'b1;

`ifdef N1_SBUS_RAM_CLR_EN
        begin
            int cyc_cnt;
            cyc_cnt = 0;
            while (a_stall && cyc_cnt < 1000) begin
                step();
                cyc_cnt++;
                if (cyc_cnt == 100) begin
                    chk("init_prb", 32'(a_prb), 32'h2);
                end
            end
            chk("init_len", 32'(cyc_cnt), 512);
            while (b_stall && cyc_cnt < 2000) begin
                step();
                cyc_cnt++;
            end
            a_req(1'b0, 1'b1, 1'b0, 12'd200, 16'h0);
            step();
            a_stb = 1'b0;
            chk("init_rs_ack", 32'(a_ack),   1);
            chk("init_rs_dat", 32'(a_dat_o), 32'h0000);
        end
`endif

        // No wait states: write then read back-to-back.
        step();
        a_req(1'b1, 1'b0, 1'b1, 12'd3, 16'hA5A5);
        chk("w0_stall_t", 32'(a_stall), 0);
        step();
        chk("w0_wr_ack", 32'(a_ack), 1);
        chk("w0_wr_err", 32'(a_err), 0);
        a_req(1'b1, 1'b0, 1'b0, 12'd3, 16'h0);
        step();
        chk("w0_rd_ack",  32'(a_ack),   1);
        chk("w0_rd_dat",  32'(a_dat_o), 32'hA5A5);
        chk("w0_stall",   32'(a_stall), 0);

        a_req(1'b0, 1'b1, 1'b1, 12'd3, 16'h1234);
        step();
        chk("rs_wr_ack",  32'(a_ack),   1);
        chk("rs_wr_dat",  32'(a_dat_o), 32'hA5A5);
        a_req(1'b1, 1'b0, 1'b0, 12'd3, 16'h0);
        step();
        chk("ps_keep_dat", 32'(a_dat_o), 32'hA5A5);
        a_req(1'b0, 1'b1, 1'b0, 12'd3, 16'h0);
        step();
        chk("rs_rd_ack", 32'(a_ack),   1);
        chk("rs_rd_dat", 32'(a_dat_o), 32'h1234);

        // Invalid accesses: out of range, both tags, all-ones RS address.
        a_req(1'b1, 1'b0, 1'b0, 12'd256, 16'h0);
        step();
        chk("oor_err", 32'(a_err),   1);
        chk("oor_ack", 32'(a_ack),   0);
        chk("oor_dat", 32'(a_dat_o), 32'h1234);
        a_req(1'b1, 1'b1, 1'b1, 12'd3, 16'hFFFF);
        step();
        chk("both_err", 32'(a_err), 1);
        chk("both_ack", 32'(a_ack), 0);
        a_req(1'b0, 1'b1, 1'b0, 12'hFFF, 16'h0);
        step();
        chk("ones_err", 32'(a_err),   1);
        chk("ones_dat", 32'(a_dat_o), 32'h1234);
        a_req(1'b1, 1'b0, 1'b0, 12'd3, 16'h0);
        step();
        chk("ram_kept_ack", 32'(a_ack),   1);
        chk("ram_kept_dat", 32'(a_dat_o), 32'hA5A5);

        // Response pending while cyc drops is suppressed, not replayed.
        a_req(1'b0, 1'b1, 1'b0, 12'd3, 16'h0);
        step();
        a_cyc = 1'b0;
        a_stb = 1'b0;
        #1;
        chk("gate_ack", 32'(a_ack),   0);
        chk("gate_dat", 32'(a_dat_o), 32'h1234);
        step();
        a_cyc = 1'b1;
        #1;
        chk("noreplay_ack", 32'(a_ack), 0);
        a_cyc = 1'b0;

        // Three wait states: stall window and pipelined second request.
        step();
        b_req(1'b1, 1'b0, 1'b1, 12'd5, 16'hBEEF);
        step();
        b_stb = 1'b0;
        chk("w3_stall1", 32'(b_stall), 1);
        chk("w3_prb1",   32'(b_prb),   1);
        chk("w3_ack1",   32'(b_ack),   0);
        step();
        chk("w3_stall2", 32'(b_stall), 1);
        step();
        chk("w3_stall3", 32'(b_stall), 1);
        chk("w3_ack3",   32'(b_ack),   0);
        step();
        chk("w3_ack4",   32'(b_ack),   1);
        chk("w3_stall4", 32'(b_stall), 0);
        chk("w3_prb4",   32'(b_prb),   0);
        b_req(1'b1, 1'b0, 1'b0, 12'd5, 16'h0);
        step();
        b_stb = 1'b0;
        chk("w3_rd_stall", 32'(b_stall), 1);
        chk("w3_rd_ack5",  32'(b_ack),   0);
        step();
        step();
        chk("w3_rd_ack7", 32'(b_ack), 0);
        step();
        chk("w3_rd_ack8", 32'(b_ack),   1);
        chk("w3_rd_dat",  32'(b_dat_o), 32'hBEEF);

        b_req(1'b1, 1'b0, 1'b0, 12'd256, 16'h0);
        step();
        b_stb = 1'b0;
        step();
        step();
        step();
        chk("w3_err",     32'(b_err),   1);
        chk("w3_err_ack", 32'(b_ack),   0);
        chk("w3_err_dat", 32'(b_dat_o), 32'hBEEF);

        // Abort in WAIT: no response, write still committed.
        b_req(1'b1, 1'b0, 1'b1, 12'd7, 16'h7777);
        step();
        b_stb = 1'b0;
        step();
        b_cyc = 1'b0;
        step();
        chk("abort_prb",   32'(b_prb),   0);
        chk("abort_stall", 32'(b_stall), 0);
        b_cyc = 1'b1;
        step();
        chk("abort_ack", 32'(b_ack), 0);
        chk("abort_err", 32'(b_err), 0);
        b_req(1'b1, 1'b0, 1'b0, 12'd7, 16'h0);
        step();
        b_stb = 1'b0;
        step();
        step();
        step();
        chk("abort_rd_ack", 32'(b_ack),   1);
        chk("abort_rd_dat", 32'(b_dat_o), 32'h7777);
        b_cyc = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
